// File: rtl/float_pkg.sv
// Shared constants, field positions and state encodings for the float datapath units.
// Pure declarations: no latency, no flow control.
package float_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UNPACK,
    ST_SHIFT,
    ST_ROUND,
    ST_PACK,
    ST_DONE
  } fti_state_e;

  typedef enum logic [1:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } fclass_e;

  localparam int          EXP_BIAS = 127;
  localparam logic [7:0]  EXP_INF  = 8'd255;
  localparam logic [31:0] INT_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MAN_MSB  = 22;
  localparam int MAN_LSB  = 0;

  localparam int RM_TRUNC = 0;
  localparam int RM_RNE   = 1;

endpackage

// File: rtl/fti_align_shift.sv
// Aligns a 24-bit significand to an integer magnitude and extracts guard/sticky bits.
// Purely combinational (zero latency); no flow control.
module fti_align_shift (
  input  logic        [23:0] i_sig,
  input  logic signed [9:0]  i_exp,
  output logic        [31:0] o_mag,
  output logic               o_guard,
  output logic               o_sticky,
  output logic               o_ovf
);

  logic [4:0]  w_lsh;
  logic [4:0]  w_rsh;
  logic [4:0]  w_gpos;
  logic [23:0] w_mask;

  always_comb begin
    o_mag    = '0;
    o_guard  = 1'b0;
    o_sticky = 1'b0;
    o_ovf    = 1'b0;
    w_lsh    = '0;
    w_rsh    = '0;
    w_gpos   = '0;
    w_mask   = '0;
    if (i_exp >= 10'sd32) begin
      o_ovf = 1'b1;
    end else if (i_exp >= 10'sd23) begin
      w_lsh = 5'(i_exp - 10'sd23);
      o_mag = {8'b0, i_sig} << w_lsh;
    end else if (i_exp >= 10'sd0) begin
      // Right shift of 1..23: guard is the first bit shifted out, sticky the rest.
      w_rsh    = 5'(10'sd23 - i_exp);
      w_gpos   = w_rsh - 5'd1;
      o_mag    = {8'b0, i_sig >> w_rsh};
      o_guard  = i_sig[w_gpos];
      w_mask   = (24'h1 << w_gpos) - 24'h1;
      o_sticky = |(i_sig & w_mask);
    end else if (i_exp == -10'sd1) begin
      o_guard  = i_sig[23];
      o_sticky = |i_sig[22:0];
    end else begin
      o_sticky = |i_sig;
    end
  end

endmodule

// File: rtl/float_to_int.sv
// IEEE-754 single to signed 32-bit integer converter, Start_Sig/Done_Sig handshake.
// Result and flags valid 5 edges after acceptance; Start_Sig ignored while busy (one op per 6 cycles).
module float_to_int
  import float_pkg::*;
#(
  parameter int ROUND_MODE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start_Sig,
  input  logic [31:0] A,
  output logic [31:0] Result,
  output logic [3:0]  Done_Sig
);

  fti_state_e r_state, w_state_nxt;

  logic [31:0]        r_a;
  logic               r_sign;
  logic signed [9:0]  r_exp;
  logic [23:0]        r_sig;
  fclass_e            r_class;
  logic [31:0]        r_mag;
  logic               r_g, r_s, r_ovf;
  logic [32:0]        r_mag33;
  logic [31:0]        r_res;
  logic               r_over, r_inv, r_inex;
  logic [31:0]        r_result;
  logic               r_o_over, r_o_inv, r_o_inex, r_done;

  logic [31:0] w_mag;
  logic        w_g, w_s, w_ovf;
  logic        w_inc;
  logic        w_gt_max, w_gt_min;
  logic [31:0] w_res;
  logic        w_over, w_inv, w_inex;
  logic [7:0]  w_e_field;
  logic [22:0] w_m_field;

  assign w_e_field = r_a[EXP_MSB:EXP_LSB];
  assign w_m_field = r_a[MAN_MSB:MAN_LSB];

  fti_align_shift u_align (
    .i_sig    (r_sig),
    .i_exp    (r_exp),
    .o_mag    (w_mag),
    .o_guard  (w_g),
    .o_sticky (w_s),
    .o_ovf    (w_ovf)
  );

  assign w_inc = (ROUND_MODE == RM_RNE) ? (r_g & (r_s | r_mag[0])) : 1'b0;

  assign w_gt_max = r_mag33 > 33'h0_7FFF_FFFF;
  assign w_gt_min = r_mag33 > 33'h0_8000_0000;

  // Negating exactly 2^31 wraps back to INT_MIN, which is the correct result.
  always_comb begin
    w_res  = r_sign ? (~r_mag33[31:0] + 32'd1) : r_mag33[31:0];
    w_over = 1'b0;
    w_inv  = 1'b0;
    if (r_class == CLS_NAN) begin
      w_res = INT_MIN;
      w_inv = 1'b1;
    end else if ((r_class == CLS_INF) || (!r_sign && (r_ovf || w_gt_max))) begin
      w_res  = INT_MAX;
      w_over = 1'b1;
    end else if (r_sign && (r_ovf || w_gt_min)) begin
      w_res  = INT_MIN;
      w_over = 1'b1;
    end
    w_inex = (r_g | r_s) & ~w_over & ~w_inv;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (Start_Sig) w_state_nxt = ST_UNPACK;
      ST_UNPACK: w_state_nxt = ST_SHIFT;
      ST_SHIFT:  w_state_nxt = ST_ROUND;
      ST_ROUND:  w_state_nxt = ST_PACK;
      ST_PACK:   w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_sig    <= '0;
      r_class  <= CLS_ZERO;
      r_mag    <= '0;
      r_g      <= 1'b0;
      r_s      <= 1'b0;
      r_ovf    <= 1'b0;
      r_mag33  <= '0;
      r_res    <= '0;
      r_over   <= 1'b0;
      r_inv    <= 1'b0;
      r_inex   <= 1'b0;
      r_result <= '0;
      r_o_over <= 1'b0;
      r_o_inv  <= 1'b0;
      r_o_inex <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (Start_Sig) begin
            r_a      <= A;
            r_o_over <= 1'b0;
            r_o_inv  <= 1'b0;
            r_o_inex <= 1'b0;
          end
        end
        ST_UNPACK: begin
          r_sign <= r_a[SIGN_BIT];
          r_exp  <= $signed({2'b00, w_e_field}) - $signed(10'(EXP_BIAS));
          // Denormals get no hidden bit, so only their mantissa feeds sticky.
          r_sig  <= {(w_e_field != 8'd0), w_m_field};
          if (w_e_field == EXP_INF) r_class <= (w_m_field != '0) ? CLS_NAN : CLS_INF;
          else if (w_e_field == 8'd0) r_class <= CLS_ZERO;
          else r_class <= CLS_NORM;
        end
        ST_SHIFT: begin
          r_mag <= w_mag;
          r_g   <= w_g;
          r_s   <= w_s;
          r_ovf <= w_ovf;
        end
        ST_ROUND: r_mag33 <= {1'b0, r_mag} + {32'b0, w_inc};
        ST_PACK: begin
          r_res  <= w_res;
          r_over <= w_over;
          r_inv  <= w_inv;
          r_inex <= w_inex;
        end
        ST_DONE: begin
          r_result <= r_res;
          r_o_over <= r_over;
          r_o_inv  <= r_inv;
          r_o_inex <= r_inex;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Result   = r_result;
  assign Done_Sig = {r_o_over, r_o_inv, r_o_inex, r_done};

endmodule

// File: tb/tb_float_to_int.sv
// Bench for float_to_int: truncating and round-to-nearest-even instances driven in lockstep.
module tb_float_to_int;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] res0, res1;
  logic [3:0]  dn0, dn1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] r0;
    logic [3:0]  d0;
    logic [31:0] r1;
    logic [3:0]  d1;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  float_to_int #(.ROUND_MODE(0)) u_trunc (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start_Sig (start),
    .A         (a),
    .Result    (res0),
    .Done_Sig  (dn0)
  );

  float_to_int #(.ROUND_MODE(1)) u_rne (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start_Sig (start),
    .A         (a),
    .Result    (res1),
    .Done_Sig  (dn1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact integer scaling with remainder-vs-half rounding.
  function automatic void model(input logic [31:0] av, input bit rne,
                                output logic [31:0] r, output logic [3:0] d);
    bit     s;
    int     e_fld;
    int     sh;
    longint m, sig, ip, rem, half, v;
    bit     up;
    s     = av[31];
    e_fld = int'(av[30:23]);
    m     = longint'(av[22:0]);
    rem   = 0;
    up    = 1'b0;
    if (e_fld == 255 && m != 0) begin
      r = 32'h8000_0000; d = 4'b0101; return;
    end
    if (e_fld == 255) begin
      r = 32'h7FFF_FFFF; d = 4'b1001; return;
    end
    if (e_fld == 0) begin
      sig = m; sh = 149;
    end else begin
      sig = m + (longint'(1) << 23); sh = 150 - e_fld;
    end
    if (sh <= 0) begin
      ip = (-sh >= 32) ? (longint'(1) << 40) : (sig << (-sh));
    end else if (sh >= 40) begin
      ip = 0; rem = sig;
    end else begin
      ip   = sig >> sh;
      rem  = sig - (ip << sh);
      half = longint'(1) << (sh - 1);
      up   = rne && ((rem > half) || (rem == half && ip[0]));
    end
    ip = ip + (up ? 64'sd1 : 64'sd0);
    v  = s ? -ip : ip;
    if (v > 64'sd2147483647) begin
      r = 32'h7FFF_FFFF; d = 4'b1001;
    end else if (v < -64'sd2147483648) begin
      r = 32'h8000_0000; d = 4'b1001;
    end else begin
      r = v[31:0]; d = {2'b00, (rem != 0), 1'b1};
    end
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0;
    repeat (3) step();
    checks++; if (res0 !== 32'h0) begin errors++; $display("FAIL reset_res_trunc got %h want 00000000", res0); end
    checks++; if (dn0 !== 4'b0) begin errors++; $display("FAIL reset_done_trunc got %b want 0000", dn0); end
    checks++; if (res1 !== 32'h0) begin errors++; $display("FAIL reset_res_rne got %h want 00000000", res1); end
    checks++; if (dn1 !== 4'b0) begin errors++; $display("FAIL reset_done_rne got %b want 0000", dn1); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic run_one(input exp_t e);
    exp_t x;
    logic [31:0] held0;
    sbq.push_back(e);
    start = 1'b1; a = e.a;
    step();
    start = 1'b0; a = $urandom;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 4) begin
        checks++;
        if (dn0[0] !== 1'b0 || dn1[0] !== 1'b0) begin
          errors++; $display("FAIL early_done a=%h got %b/%b want 0/0", e.a, dn0[0], dn1[0]);
        end
      end
    end
    if (sbq.size() == 0) begin
      checks++; errors++; $display("FAIL scoreboard_empty a=%h got 0 entries want 1", e.a);
    end else begin
      x = sbq.pop_front();
      checks++; if (res0 !== x.r0) begin errors++; $display("FAIL res_trunc a=%h got %h want %h", x.a, res0, x.r0); end
      checks++; if (dn0 !== x.d0) begin errors++; $display("FAIL done_trunc a=%h got %b want %b", x.a, dn0, x.d0); end
      checks++; if (res1 !== x.r1) begin errors++; $display("FAIL res_rne a=%h got %h want %h", x.a, res1, x.r1); end
      checks++; if (dn1 !== x.d1) begin errors++; $display("FAIL done_rne a=%h got %b want %b", x.a, dn1, x.d1); end
    end
    held0 = res0;
    step();
    checks++;
    if (dn0[0] !== 1'b0 || res0 !== held0) begin
      errors++; $display("FAIL done_pulse_hold a=%h got done=%b res=%h want done=0 res=%h", e.a, dn0[0], res0, held0);
    end
  endtask

  task automatic test_convert();
    logic [31:0] va [15];
    logic [31:0] vr0 [15];
    logic [3:0]  vd0 [15];
    logic [31:0] vr1 [15];
    logic [3:0]  vd1 [15];
    exp_t e;
    va  = '{32'h3FC0_0000, 32'hC2F6_E979, 32'h4020_0000, 32'h4060_0000, 32'h4F00_0000,
            32'hCF00_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'h0000_0001, 32'h0000_0000,
            32'h8000_0000, 32'h4EFF_FFFF, 32'h3F00_0000, 32'h3F40_0000, 32'hBFC0_0000};
    vr0 = '{32'h1, 32'hFFFF_FF85, 32'h2, 32'h3, 32'h7FFF_FFFF,
            32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h0,
            32'h0, 32'h7FFF_FF80, 32'h0, 32'h0, 32'hFFFF_FFFF};
    vd0 = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b1001,
            4'b0001, 4'b1001, 4'b0101, 4'b0011, 4'b0001,
            4'b0001, 4'b0001, 4'b0011, 4'b0011, 4'b0011};
    vr1 = '{32'h2, 32'hFFFF_FF85, 32'h2, 32'h4, 32'h7FFF_FFFF,
            32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'h0,
            32'h0, 32'h7FFF_FF80, 32'h0, 32'h1, 32'hFFFF_FFFE};
    vd1 = vd0;
    for (int i = 0; i < 15; i++) begin
      e.a = va[i]; e.r0 = vr0[i]; e.d0 = vd0[i]; e.r1 = vr1[i]; e.d1 = vd1[i];
      run_one(e);
    end
  endtask

  task automatic test_reset_abort();
    bit seen;
    exp_t e;
    seen  = 1'b0;
    start = 1'b1; a = 32'h3FC0_0000;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (res0 !== 32'h0 || dn0 !== 4'b0 || res1 !== 32'h0 || dn1 !== 4'b0) begin
      errors++; $display("FAIL abort_clear got %h/%b %h/%b want 0/0", res0, dn0, res1, dn1);
    end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (dn0[0] === 1'b1 || dn1[0] === 1'b1) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL abort_no_done got pulse=1 want 0"); end
    checks++; if (res0 !== 32'h0) begin errors++; $display("FAIL abort_result got %h want 00000000", res0); end
    e.a = 32'h3FC0_0000; e.r0 = 32'h1; e.d0 = 4'b0011; e.r1 = 32'h2; e.d1 = 4'b0011;
    run_one(e);
  endtask

  task automatic test_back_to_back();
    exp_t e, x;
    bit   want_done;
    logic [31:0] r;
    logic [3:0]  d;
    int   sel;
    for (int c = 0; c < 66; c++) begin
      sel = $urandom_range(0, 15);
      a[31]    = 1'($urandom_range(0, 1));
      a[30:23] = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom_range(110, 160));
      a[22:0]  = 23'($urandom);
      start    = (c < 60);
      if ((c % 6) == 0 && c < 60) begin
        e.a = a;
        model(a, 1'b0, r, d); e.r0 = r; e.d0 = d;
        model(a, 1'b1, r, d); e.r1 = r; e.d1 = d;
        sbq.push_back(e);
      end
      step();
      want_done = ((c % 6) == 5) && (c < 60);
      checks++;
      if (dn0[0] !== want_done || dn1[0] !== want_done) begin
        errors++; $display("FAIL b2b_done_timing cycle=%0d got %b/%b want %b", c, dn0[0], dn1[0], want_done);
      end
      if (dn0[0] === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_scoreboard_empty cycle=%0d got 0 entries want 1", c);
        end else begin
          x = sbq.pop_front();
          checks++; if (res0 !== x.r0) begin errors++; $display("FAIL b2b_res_trunc a=%h got %h want %h", x.a, res0, x.r0); end
          checks++; if (dn0 !== x.d0) begin errors++; $display("FAIL b2b_done_trunc a=%h got %b want %b", x.a, dn0, x.d0); end
          checks++; if (res1 !== x.r1) begin errors++; $display("FAIL b2b_res_rne a=%h got %h want %h", x.a, res1, x.r1); end
          checks++; if (dn1 !== x.d1) begin errors++; $display("FAIL b2b_done_rne a=%h got %b want %b", x.a, dn1, x.d1); end
        end
      end
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL b2b_leftover got %0d entries want 0", sbq.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    test_reset();
    test_convert();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/float_to_int.md
Name: float_to_int

Overview:
- Multi-cycle converter from IEEE-754 single precision to a signed 32-bit two's-complement integer.
- Sits downstream of the float adder. It consumes the adder's Result word and returns integer values to the fixed-point datapath, so it is the float-to-integer direction of the float datapath.
- Uses the same Start_Sig / Done_Sig handshake style as the other float units.

Parameters:
ROUND_MODE  0  rounding mode: 0 = toward zero (truncate), 1 = round to nearest, ties to even

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
Start_Sig  input  1  conversion request; sampled only in IDLE
A  input  32  IEEE-754 single-precision operand; captured on the accepting edge
Result  output  32  signed integer result; held until the next completion
Done_Sig  output  4  {isOver, isInvalid, isInexact, isDone}

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - rst_n low clears the FSM to IDLE, Result to 0, all Done_Sig bits to 0, and all internal registers.
  - Reset mid-conversion aborts the conversion: no Done pulse, Result stays 0.
- FSM: IDLE -> UNPACK -> SHIFT -> ROUND -> PACK -> DONE -> IDLE.
  - IDLE: when Start_Sig=1, capture A and go to UNPACK.
  - UNPACK:
    - split sign S, exponent E, mantissa M;
    - compute e = E - 127 as a 10-bit signed value;
    - classify the operand as NaN (E=255, M!=0), Inf (E=255, M=0), zero/denormal (E=0), or normal.
  - SHIFT: sig = {1,M}, 24 bits. Produce a 32-bit magnitude mag, a guard bit g and a sticky bit s:
    - e >= 23: mag = sig << (e-23); g=0, s=0.
    - 0 <= e < 23: mag = sig >> (23-e); g = sig[22-e]; s = OR of sig below bit 22-e.
    - e = -1: mag = 0; g=1; s = |M.
    - e < -1, or denormal: mag = 0; g=0; s = (sig!=0).
    - e >= 32: mag is don't-care; the overflow flag is pre-set.
  - ROUND:
    - ROUND_MODE=0: mag unchanged.
    - ROUND_MODE=1: mag += g & (s | mag[0]).
    - Use a 33-bit adder so a carry out of bit 31 is visible.
  - PACK (priority order):
    - NaN -> Result 32'h8000_0000, isInvalid=1.
    - Inf, or magnitude > 2^31-1 with S=0 -> Result 32'h7FFF_FFFF, isOver=1.
    - Magnitude > 2^31 with S=1 -> Result 32'h8000_0000, isOver=1.
    - Magnitude = 2^31 with S=1 -> Result 32'h8000_0000, no overflow.
    - Otherwise Result = S ? -mag : mag.
    - isInexact = (g|s), and only when no overflow or invalid is flagged.
    - Zero and denormal inputs give Result 0; isInexact is set if M != 0.
  - DONE: isDone=1 for exactly one cycle, then return to IDLE.
- Latency and throughput:
  - If Start_Sig is accepted at edge N, Result, flags and isDone are valid after edge N+5. isDone clears after edge N+6.
  - Start_Sig held high continuously gives one conversion per 6 cycles.
  - Start_Sig is ignored outside IDLE. Deasserting it mid-conversion does not abort.
- Flag lifetime:
  - isOver, isInvalid and isInexact are cleared on acceptance of a new Start_Sig.
  - Otherwise they stay with the Result they describe.
- The sign of negative zero is ignored: -0.0 gives Result 0.

Decomposition:
- Shared package float_pkg:
  - FSM state encodings;
  - constants EXP_BIAS=127, EXP_INF=255, INT_MAX=32'h7FFF_FFFF, INT_MIN=32'h8000_0000;
  - bit-field positions for sign, exponent and mantissa;
  - rounding-mode codes.
  The float adder reuses the same constants.
- One combinational sub-module, fti_align_shift: takes sig and e; returns mag, g, s and the e>=32 overflow indication.
- The FSM, rounding, saturation and negation stay in float_to_int.

Test Plan:
- 1.5 (32'h3FC0_0000): ROUND_MODE=1 -> Result 2, Done_Sig=4'b0011. ROUND_MODE=0 -> Result 1, Done_Sig=4'b0011. Both values appear 5 cycles after Start_Sig is accepted.
- -123.456 (32'hC2F6_E979), ROUND_MODE=0 -> Result 32'hFFFF_FF85 (-123), isInexact=1. Ties under ROUND_MODE=1: 2.5 (32'h4020_0000) -> 2; 3.5 (32'h4060_0000) -> 4.
- Boundaries:
  - 2^31 (32'h4F00_0000) -> 32'h7FFF_FFFF, isOver=1.
  - -2^31 (32'hCF00_0000) -> 32'h8000_0000, isOver=0.
  - +Inf (32'h7F80_0000) -> 32'h7FFF_FFFF, isOver=1.
- NaN (32'h7FC0_0000) -> 32'h8000_0000, isInvalid=1. Denormal 32'h0000_0001 -> Result 0, isInexact=1. 0.0 -> Result 0, Done_Sig=4'b0001.
- rst_n pulsed low 2 cycles after Start_Sig is accepted -> no isDone pulse, Result=0. A new Start_Sig after release converts normally.
- Start_Sig held high with A changing every cycle -> conversions every 6 cycles. Each Result matches the A value present at its accepting edge, and isDone pulses exactly one cycle per conversion.
